// File: rtl/dmr_stream_fork.sv
// dmr_stream_fork: one-entry buffer that forks a stream to NUM_OUT redundant sinks.
// Define DMR_STREAM_FORK_ERR_CNT_EN to add the saturating err_cnt_o counter.
module dmr_stream_fork #(
   parameter type         T         = logic,
   parameter int unsigned NUM_OUT   = 2,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               repeat_i,
   output logic               error_o,
   input  logic               valid_i,
   output logic               ready_o,
   input  T                   data_i,
   output logic [NUM_OUT-1:0] valid_o,
   input  logic [NUM_OUT-1:0] ready_i,
`ifdef DMR_STREAM_FORK_ERR_CNT_EN
   output logic [ERR_CNT_W-1:0] err_cnt_o,
`endif
   output T                   data_o [NUM_OUT]
);

   typedef enum logic {
      EMPTY,
      FULL
   } state_e;

   state_e state_q, state_d;
   T       data_q;
   logic   full;
   logic   all_rdy;
   logic   any_rdy;
   logic   complete;
   logic   release_item;
   logic   load;

   if (NUM_OUT < 2 || ERR_CNT_W < 1) begin : g_bad_param
      $error("dmr_stream_fork: NUM_OUT must be >= 2, ERR_CNT_W >= 1");
   end

   assign full         = (state_q == FULL);
   assign all_rdy      = &ready_i;
   assign any_rdy      = |ready_i;
   assign complete     = full && all_rdy;
   assign release_item = complete && !repeat_i;
   assign load         = ready_o && valid_i;

   // ready_o depends only on state, ready_i and repeat_i, never on valid_i
   always_comb begin
      state_d = state_q;
      ready_o = 1'b1;
      valid_o = '0;
      error_o = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (valid_i) state_d = FULL;
         end
         FULL: begin
            valid_o = '1;
            error_o = all_rdy != any_rdy;
            ready_o = release_item;
            if (release_item && !valid_i) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load) data_q <= data_i;
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_OUT; k++) data_o[k] = data_q;
   end

`ifdef DMR_STREAM_FORK_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_cnt_q <= '0;
      end else if (error_o && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmr_stream_fork.sv
// tb_dmr_stream_fork: vector table, directed corners and a queue-based
// reference model for random traffic.
module tb_dmr_stream_fork;

   typedef logic [7:0] byte_t;

   typedef struct {
      logic       v;
      byte_t      d;
      logic [1:0] r;
      logic       rep;
      logic [1:0] ev;
      logic       er;
      logic       ee;
      byte_t      ed;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       repeat_i;
   logic       error_o;
   logic       valid_i;
   logic       ready_o;
   byte_t      data_i;
   logic [1:0] valid_o;
   logic [1:0] ready_i;
   byte_t      data_o [2];

   int total;
   int bad;

   byte_t held[$];
   byte_t dut_log[$];
   byte_t last;
   int    errs;

`ifdef DMR_STREAM_FORK_ERR_CNT_EN
   logic [7:0] err_cnt;
   logic [1:0] err_cnt2;
   logic       error2;
   logic       ready2;
   logic [1:0] valid2;
   byte_t      data2 [2];

   dmr_stream_fork #(
      .T(byte_t), .NUM_OUT(2), .ERR_CNT_W(2)
   ) u_sat (
      .clk_i(clk), .rst_ni(rst_n), .repeat_i(repeat_i),
      .error_o(error2), .valid_i(valid_i), .ready_o(ready2),
      .data_i(data_i), .valid_o(valid2), .ready_i(ready_i),
      .err_cnt_o(err_cnt2), .data_o(data2)
   );
`endif

   dmr_stream_fork #(
      .T(byte_t), .NUM_OUT(2), .ERR_CNT_W(8)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .repeat_i(repeat_i),
      .error_o(error_o), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
`ifdef DMR_STREAM_FORK_ERR_CNT_EN
      .err_cnt_o(err_cnt),
`endif
      .data_o(data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      held.delete();
      last = 8'h00;
      errs = 0;
   endtask

   task automatic chk_cnt();
`ifdef DMR_STREAM_FORK_ERR_CNT_EN
      chk("err_cnt", int'(err_cnt), errs > 255 ? 255 : errs);
      chk("err_cnt_sat", int'(err_cnt2), errs > 3 ? 3 : errs);
`endif
   endtask

   // drive one cycle, check outputs mid-cycle, advance the model at the edge
   task automatic cyc(input logic v, input byte_t d, input logic [1:0] r,
                      input logic rep, output logic [1:0] ov,
                      output logic ordy, output logic oerr,
                      output byte_t od);
      logic have;
      logic mix;
      logic all;
      logic xrdy;
      valid_i  = v;
      data_i   = d;
      ready_i  = r;
      repeat_i = rep;
      have = held.size() != 0;
      all  = r == 2'b11;
      mix  = r == 2'b01 || r == 2'b10;
      xrdy = !have || (all && !rep);
      @(negedge clk);
      ov   = valid_o;
      ordy = ready_o;
      oerr = error_o;
      od   = data_o[0];
      chk("valid_o", int'(valid_o), have ? 3 : 0);
      chk("ready_o", int'(ready_o), int'(xrdy));
      chk("error_o", int'(error_o), int'(have && mix));
      chk("data_o0", int'(data_o[0]), int'(have ? held[0] : last));
      chk("data_o1", int'(data_o[1]), int'(have ? held[0] : last));
      chk_cnt();
      if (valid_o == 2'b11 && ready_i == 2'b11) dut_log.push_back(data_o[0]);
      @(posedge clk);
      if (have && mix) errs++;
      if (have && all && !rep) void'(held.pop_front());
      if (xrdy && v) begin
         held.push_back(d);
         last = d;
      end
      #1;
   endtask

   vec_t       tbl [18];
   logic [1:0] ov;
   logic       ordy;
   logic       oerr;
   byte_t      od;
   int         base;
   int         n77;

   initial begin
      total = 0;
      bad   = 0;
      tbl[0]  = '{1'b1, 8'hA5, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 8'h00, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0, 8'hA5};
      tbl[2]  = '{1'b0, 8'h00, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA5};
      tbl[3]  = '{1'b1, 8'h3C, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA5};
      tbl[4]  = '{1'b0, 8'h00, 2'b01, 1'b0, 2'b11, 1'b0, 1'b1, 8'h3C};
      tbl[5]  = '{1'b0, 8'h00, 2'b01, 1'b0, 2'b11, 1'b0, 1'b1, 8'h3C};
      tbl[6]  = '{1'b0, 8'h00, 2'b01, 1'b0, 2'b11, 1'b0, 1'b1, 8'h3C};
      tbl[7]  = '{1'b1, 8'h99, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0, 8'h3C};
      tbl[8]  = '{1'b0, 8'h00, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0, 8'h99};
      tbl[9]  = '{1'b1, 8'h77, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 8'h99};
      tbl[10] = '{1'b1, 8'h88, 2'b11, 1'b1, 2'b11, 1'b0, 1'b0, 8'h77};
      tbl[11] = '{1'b1, 8'h88, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0, 8'h77};
      tbl[12] = '{1'b0, 8'h00, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0, 8'h88};
      tbl[13] = '{1'b0, 8'h00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 8'h88};
      tbl[14] = '{1'b1, 8'h5A, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 8'h88};
      tbl[15] = '{1'b0, 8'h00, 2'b10, 1'b0, 2'b11, 1'b0, 1'b1, 8'h5A};
      tbl[16] = '{1'b0, 8'h00, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0, 8'h5A};
      tbl[17] = '{1'b0, 8'h00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 8'h5A};

      rst_n    = 1'b0;
      valid_i  = 1'b0;
      data_i   = 8'h00;
      ready_i  = 2'b00;
      repeat_i = 1'b0;
      model_reset();
      #2;
      chk("rst valid_o", int'(valid_o), 0);
      chk("rst ready_o", int'(ready_o), 1);
      chk("rst error_o", int'(error_o), 0);
      chk("rst data_o", int'(data_o[0]), 0);
      chk_cnt();
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         cyc(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].rep, ov, ordy, oerr, od);
         chk($sformatf("tbl%0d valid", i), int'(ov), int'(tbl[i].ev));
         chk($sformatf("tbl%0d ready", i), int'(ordy), int'(tbl[i].er));
         chk($sformatf("tbl%0d error", i), int'(oerr), int'(tbl[i].ee));
         chk($sformatf("tbl%0d data", i), int'(od), int'(tbl[i].ed));
      end
      n77 = 0;
      foreach (dut_log[i]) if (dut_log[i] == 8'h77) n77++;
      chk("repeat 77 completions", n77, 2);
      n77 = 0;
      foreach (dut_log[i]) if (dut_log[i] == 8'h3C) n77++;
      chk("mismatch 3C completions", n77, 1);

      base = dut_log.size();
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b1, byte_t'(i), 2'b11, 1'b0, ov, ordy, oerr, od);
         if (i > 1) chk("stream ready_o", int'(ordy), 1);
      end
      cyc(1'b0, 8'h00, 2'b11, 1'b0, ov, ordy, oerr, od);
      chk("stream count", dut_log.size() - base, 16);
      for (int i = 0; i < 16 && base + i < dut_log.size(); i++)
         chk("stream order", int'(dut_log[base + i]), i + 1);

      cyc(1'b1, 8'hC3, 2'b00, 1'b0, ov, ordy, oerr, od);
      for (int i = 0; i < 6; i++)
         cyc(1'b0, 8'h00, 2'b10, 1'b0, ov, ordy, oerr, od);
      cyc(1'b0, 8'h00, 2'b11, 1'b0, ov, ordy, oerr, od);
      cyc(1'b0, 8'h00, 2'b10, 1'b0, ov, ordy, oerr, od);

      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), byte_t'($urandom),
             2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
             ov, ordy, oerr, od);
      end

      cyc(1'b1, 8'hFF, 2'b00, 1'b0, ov, ordy, oerr, od);
      cyc(1'b0, 8'h00, 2'b00, 1'b0, ov, ordy, oerr, od);
      base = dut_log.size();
      rst_n = 1'b0;
      #1;
      chk("midrst valid_o", int'(valid_o), 0);
      chk("midrst ready_o", int'(ready_o), 1);
      chk("midrst error_o", int'(error_o), 0);
      chk("midrst data_o", int'(data_o[0]), 0);
      model_reset();
      chk_cnt();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 8'h00, 2'b11, 1'b0, ov, ordy, oerr, od);
      chk("no stale FF", dut_log.size() - base, 0);
      cyc(1'b1, 8'h12, 2'b11, 1'b0, ov, ordy, oerr, od);
      cyc(1'b0, 8'h00, 2'b11, 1'b0, ov, ordy, oerr, od);
      chk("post-rst item", dut_log.size() - base, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmr_stream_fork.md
DMR_STREAM_FORK -- requirements
Module: dmr_stream_fork

Interface
REQ-001 Parameter T SHALL default to logic; it is the payload type.
REQ-002 Parameter NUM_OUT SHALL default to 2; it is the number of redundant destinations, legal range >= 2.
REQ-003 Parameter ERR_CNT_W SHALL default to 8; it is the error counter width.
REQ-004 clk_i SHALL be an input of width 1 and is the single clock; all state updates on its rising edge.
REQ-005 rst_ni SHALL be an input of width 1 and is the reset; reset is asynchronous and active-low.
REQ-006 repeat_i SHALL be an input of width 1 that requests re-presentation of the current item after its handshake.
REQ-007 error_o SHALL be an output of width 1 that flags disagreement between the destination ready signals.
REQ-008 valid_i SHALL be an input of width 1 carrying the source valid.
REQ-009 ready_o SHALL be an output of width 1 carrying the source ready.
REQ-010 data_i SHALL be an input of type T carrying the source payload.
REQ-011 valid_o SHALL be an output of width NUM_OUT carrying the per-destination valid.
REQ-012 ready_i SHALL be an input of width NUM_OUT carrying the per-destination ready.
REQ-013 data_o SHALL be an output of NUM_OUT x T carrying the per-destination payload.
REQ-014 err_cnt_o SHALL be an output of width ERR_CNT_W carrying the error count; it exists only per REQ-031.

Function
REQ-015 The block SHALL be a one-entry buffer with states Empty and Full, and a register data_q of type T.
REQ-016 In Empty: valid_o SHALL be all zeros, ready_o SHALL be 1, error_o SHALL be 0, ready_i SHALL be ignored, and repeat_i SHALL be ignored.
REQ-017 In Empty with valid_i=1: data_i SHALL be latched into data_q and the state SHALL become Full; the first output valid appears one cycle after the input handshake.
REQ-018 In Full: every valid_o bit SHALL be 1 and every data_o[k] SHALL equal data_q, bit-identical across all k.
REQ-019 error_o SHALL be 1 in Full when the ready_i bits are not all equal; this is combinational, in the same cycle.
REQ-020 A completion SHALL occur in Full when ready_i is all ones; partial ready (any mix) SHALL never complete and the state SHALL stay Full with data_q unchanged.
REQ-021 On a completion with repeat_i=1: ready_o SHALL be 0, the state SHALL stay Full, and data_q SHALL be held, so the same item is offered again on the next cycle.
REQ-022 On a completion with repeat_i=0: ready_o SHALL be 1 in the same cycle. If valid_i=1, the new data SHALL be latched and the state SHALL stay Full (back-to-back, full throughput); otherwise the state SHALL become Empty.
REQ-023 In Full without a completion: ready_o SHALL be 0.
REQ-024 ready_o SHALL not depend combinationally on valid_i.
REQ-025 valid_o SHALL never be withdrawn, and data_o SHALL never change, while in Full before a completion; this holds regardless of error_o.

Reset
REQ-026 On rst_ni=0 the state SHALL become Empty and data_q SHALL become '0, asynchronously.
REQ-027 During reset the outputs SHALL be: valid_o=0, ready_o=1, error_o=0, data_o='0, err_cnt_o=0.
REQ-028 A reset asserted while in Full SHALL drop the held item, with no completion reported.
REQ-029 After reset release, the first handshake SHALL be accepted on the first rising edge.

Configuration
REQ-030 The macro DMR_STREAM_FORK_ERR_CNT_EN SHALL control the error counter.
REQ-031 With DMR_STREAM_FORK_ERR_CNT_EN defined: port err_cnt_o SHALL exist and hold a counter that increments by 1 on every clock edge where error_o=1, saturates at all-ones (no wrap), and resets to 0.
REQ-032 Without DMR_STREAM_FORK_ERR_CNT_EN: port err_cnt_o and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Single transfer: NUM_OUT=2, T=logic[7:0]; valid_i=1, data_i=8'hA5 for 1 cycle; ready_i=2'b11 -> next cycle valid_o=2'b11, data_o={A5,A5}; one cycle later valid_o=0.
REQ-034 Streaming: continuous valid_i with 8'h01..8'h10 and ready_i=2'b11 -> 16 items out in order, one per cycle, ready_o constantly 1, error_o=0.
REQ-035 Ready mismatch: Full with 8'h3C, ready_i=2'b01 for 3 cycles then 2'b11 -> error_o=1 for exactly 3 cycles, 8'h3C held and then completed once, err_cnt_o=3 when enabled.
REQ-036 Repeat: Full with 8'h77, ready_i=2'b11, repeat_i=1 for 1 cycle -> ready_o=0 that cycle, 8'h77 is presented again and completes twice in total, and the next input is accepted only on the second completion.
REQ-037 Saturation: ERR_CNT_W=2, ready_i=2'b10 held for 6 cycles in Full -> err_cnt_o=3 and stays 3.
REQ-038 Mid-operation reset: rst_ni pulled low while Full with 8'hFF and ready_i=0 -> valid_o=0 and ready_o=1 immediately; after release, data_o='0 and no stale 8'hFF is ever issued.
